instr_decode_stage: RTL and testbench
=====================================

# instr_decode_stage

Decode/issue stage directly upstream of the register bank. Accepts 32-bit instructions over a valid/ready handshake, splits them into opcode, destination, source addresses and immediate, and holds them in one output register that drives the register bank and ALU. A 16-entry scoreboard stalls issue while any referenced register still has a write in flight. Pending bits clear on writeback strobes.

## Interface
- SB_ENABLE, default 1: 1 enables scoreboard hazard stalls; 0 never stalls on hazards, but the mask is still maintained.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream instruction valid
- in_ready  output  1  stage accepts in_instr this cycle
- in_instr  input  32  fields: [31:28] opcode, [27:24] dest, [23:20] srcadd1, [19:16] srcadd2, [15:0] imm
- out_valid  output  1  decoded instruction held
- out_ready  input  1  downstream consumes held instruction
- opcode  output  4  held opcode
- dest, srcadd1, srcadd2  output  4 each  held register addresses
- imm  output  16  held immediate, zero-extended downstream
- wr_en  output  1  held instruction writes dest
- wb_valid  input  1  writeback completes this cycle
- wb_dest  input  4  register written back
- flush  input  1  discard held instruction
- busy_mask  output  16  scoreboard pending bits, bit n = register n

## Operation
- Non-writing opcodes: 1111 NO-OP, 1000 STR, 1010 CMP. wr_en = 1 for every other opcode.
- Hazard rules:
  - A NO-OP has no hazard check.
  - Any other opcode is hazarded if pending_eff is set for dest, srcadd1 or srcadd2.
  - pending_eff = busy_mask & ~(wb_valid ? onehot(wb_dest) : 0). This is a same-cycle writeback bypass.
- in_ready = !rst && !flush && (!out_valid || out_ready) && !(SB_ENABLE && hazard(in_instr)).
- Accept = in_valid && in_ready. On accept:
  - the output register loads all fields and wr_en;
  - out_valid is set to 1.
- The held instruction retires when out_valid && out_ready && no accept. out_valid then clears.
- Scoreboard update each cycle, in priority order:
  1. Set onehot(dest) if accept && wr_en(in_instr).
  2. Clear onehot(wb_dest) if wb_valid.
  3. If flush && out_valid && wr_en, clear the held dest.
  - Set beats clear on the same bit.
- wb_valid for a register that is not pending is ignored.
- Flush:
  - out_valid clears next cycle.
  - The held fields are not required to change.
  - No accept occurs in a flush cycle.
- Reset values:
  - out_valid 0, opcode 4'b1111, dest/srcadd1/srcadd2 0, imm 0, wr_en 0, busy_mask 0.
  - in_ready is 0 during the reset cycle.

## Timing
- Latency: accept in cycle t gives out_valid = 1 in cycle t+1.
- Throughput is one instruction per cycle while out_ready = 1 and there are no hazards.
- in_ready is combinational from in_instr, busy_mask, wb_valid/wb_dest, out_valid, out_ready and flush.
- Output fields are registered. They are stable while out_valid && !out_ready.
- Dependent instruction: writer of r3 accepted in cycle t, so busy_mask[3] = 1 from t+1. A reader of r3 stalls until the cycle wb_valid && wb_dest = 3, and is accepted in that same cycle.
- Reset mid-operation: the held instruction is lost and all pending bits clear on the next edge.

## Structure
- Shared package cpu_isa_pkg, containing:
  - opcode localparams (OP_NOP = 4'b1111, OP_STR = 4'b1000, OP_CMP = 4'b1010);
  - field bit positions;
  - function writes_reg(opcode), also used by the register bank write gate.
- Sub-module reg_scoreboard, containing:
  - the 16-bit pending mask;
  - set/clear ports with set priority;
  - three combinational lookup ports with the writeback bypass.
- Top level holds the handshake logic and the output register.

## Test plan
- Reset and pass-through:
  - Stimulus: assert rst; then send in_instr = 32'h1321_00AB with out_ready = 1.
  - Response: all outputs at reset values; then out_valid the next cycle with opcode 1, dest 3, srcadd1 2, srcadd2 1, imm 16'h00AB, wr_en 1; busy_mask = 16'h0008.
- RAW stall:
  - Stimulus: writer to r3, then a reader with srcadd1 = 3.
  - Response: in_ready = 0 until wb_valid with wb_dest = 3; reader accepted in that cycle; busy_mask[3] stays 1 because the reader writes r3? Only if its dest is 3. With reader dest 5, busy_mask = 16'h0020.
- Non-writers:
  - Stimulus: STR and CMP with dest = 7, then NO-OP with every field equal to 4'hF.
  - Response: wr_en = 0, busy_mask unchanged; NO-OP accepted even while busy_mask = 16'hFFFF.
- Backpressure:
  - Stimulus: hold out_ready = 0 for 3 cycles with in_valid = 1.
  - Response: in_ready = 0; held fields stable; on release, next instruction accepted in the same cycle.
- Flush:
  - Stimulus: flush while holding a writer to r9.
  - Response: out_valid = 0 next cycle; busy_mask[9] = 0; input not accepted in the flush cycle.
- Set/clear collision:
  - Stimulus: wb_valid with wb_dest = 4 in the same cycle a new writer to r4 is accepted.
  - Response: busy_mask[4] = 1.
  - Stimulus: SB_ENABLE = 0 with a dependent pair.
  - Response: no stall.

Source files
------------

// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the decode stage and the register bank.
// Holds the opcode encodings, instruction field positions, the write-gate
// function shared with the register bank, and a one-hot register helper.
package cpu_isa_pkg;

  localparam int NUM_REGS = 16;
  localparam int REG_AW   = 4;
  localparam int OPC_W    = 4;
  localparam int IMM_W    = 16;

  localparam logic [OPC_W-1:0] OP_NOP = 4'b1111;
  localparam logic [OPC_W-1:0] OP_STR = 4'b1000;
  localparam logic [OPC_W-1:0] OP_CMP = 4'b1010;

  // Instruction field LSB positions
  localparam int OPC_LSB  = 28;
  localparam int DEST_LSB = 24;
  localparam int SRC1_LSB = 20;
  localparam int SRC2_LSB = 16;
  localparam int IMM_LSB  = 0;

  function automatic logic writes_reg(input logic [OPC_W-1:0] opc);
    return !((opc == OP_NOP) || (opc == OP_STR) || (opc == OP_CMP));
  endfunction

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] addr);
    logic [NUM_REGS-1:0] v;
    v       = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard, one bit per architectural register.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   set_en_i/set_addr_i mark a register pending (wins over any clear)
//   wb_valid_i/wb_dest_i writeback clear; also bypassed into the lookups
//   flush_clr_i/flush_addr_i clear the dest of a discarded instruction
//   rd_addr{0,1,2}_i / pend{0,1,2}_o  combinational pending lookups
//   busy_mask_o         registered pending mask
module reg_scoreboard
  import cpu_isa_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en_i,
  input  logic [REG_AW-1:0]   set_addr_i,
  input  logic                wb_valid_i,
  input  logic [REG_AW-1:0]   wb_dest_i,
  input  logic                flush_clr_i,
  input  logic [REG_AW-1:0]   flush_addr_i,
  input  logic [REG_AW-1:0]   rd_addr0_i,
  input  logic [REG_AW-1:0]   rd_addr1_i,
  input  logic [REG_AW-1:0]   rd_addr2_i,
  output logic                pend0_o,
  output logic                pend1_o,
  output logic                pend2_o,
  output logic [NUM_REGS-1:0] busy_mask_o
);

  logic [NUM_REGS-1:0] mask_q, mask_d;
  logic [NUM_REGS-1:0] set_vec, wb_vec, fl_vec, pend_eff;

  always_comb begin
    set_vec  = set_en_i    ? reg_onehot(set_addr_i)   : '0;
    wb_vec   = wb_valid_i  ? reg_onehot(wb_dest_i)    : '0;
    fl_vec   = flush_clr_i ? reg_onehot(flush_addr_i) : '0;
    // A writeback landing this cycle already satisfies its readers.
    pend_eff = mask_q & ~wb_vec;
    mask_d   = (mask_q & ~wb_vec & ~fl_vec) | set_vec;
  end

  always_ff @(posedge clk) begin
    if (rst) mask_q <= '0;
    else     mask_q <= mask_d;
  end

  assign pend0_o     = pend_eff[rd_addr0_i];
  assign pend1_o     = pend_eff[rd_addr1_i];
  assign pend2_o     = pend_eff[rd_addr2_i];
  assign busy_mask_o = mask_q;

endmodule

// File: rtl/instr_decode_stage.sv
// Decode/issue stage in front of the register bank.
// Accepts an instruction over in_valid/in_ready, splits it into fields and
// holds them in one output register (out_valid/out_ready). Issue stalls while
// any referenced register has a write in flight, unless SB_ENABLE is 0.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid, in_ready, in_instr  upstream handshake and instruction
//   out_valid, out_ready          downstream handshake
//   opcode, dest, srcadd1, srcadd2, imm, wr_en  held decoded fields
//   wb_valid, wb_dest             writeback strobe
//   flush                         discard the held instruction
//   busy_mask                     scoreboard pending bits
module instr_decode_stage
  import cpu_isa_pkg::*;
#(
  parameter bit SB_ENABLE = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OPC_W-1:0]    opcode,
  output logic [REG_AW-1:0]   dest,
  output logic [REG_AW-1:0]   srcadd1,
  output logic [REG_AW-1:0]   srcadd2,
  output logic [IMM_W-1:0]    imm,
  output logic                wr_en,
  input  logic                wb_valid,
  input  logic [REG_AW-1:0]   wb_dest,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy_mask
);

  logic [OPC_W-1:0]  in_opc;
  logic [REG_AW-1:0] in_dest, in_src1, in_src2;
  logic [IMM_W-1:0]  in_imm;
  logic              in_wr;

  assign in_opc  = in_instr[OPC_LSB  +: OPC_W];
  assign in_dest = in_instr[DEST_LSB +: REG_AW];
  assign in_src1 = in_instr[SRC1_LSB +: REG_AW];
  assign in_src2 = in_instr[SRC2_LSB +: REG_AW];
  assign in_imm  = in_instr[IMM_LSB  +: IMM_W];
  assign in_wr   = writes_reg(in_opc);

  logic              out_valid_q, out_valid_d;
  logic [OPC_W-1:0]  opcode_q, opcode_d;
  logic [REG_AW-1:0] dest_q, dest_d, src1_q, src1_d, src2_q, src2_d;
  logic [IMM_W-1:0]  imm_q, imm_d;
  logic              wr_en_q, wr_en_d;

  logic pend_dest, pend_src1, pend_src2;
  logic hazard, accept, flush_clr;

  // Checks all three addresses even when the opcode ignores some of them.
  assign hazard    = (in_opc != OP_NOP) && (pend_dest || pend_src1 || pend_src2);
  assign in_ready  = !rst && !flush && (!out_valid_q || out_ready) && !(SB_ENABLE && hazard);
  assign accept    = in_valid && in_ready;
  assign flush_clr = flush && out_valid_q && wr_en_q;

  reg_scoreboard u_sb (
    .clk          (clk),
    .rst          (rst),
    .set_en_i     (accept && in_wr),
    .set_addr_i   (in_dest),
    .wb_valid_i   (wb_valid),
    .wb_dest_i    (wb_dest),
    .flush_clr_i  (flush_clr),
    .flush_addr_i (dest_q),
    .rd_addr0_i   (in_dest),
    .rd_addr1_i   (in_src1),
    .rd_addr2_i   (in_src2),
    .pend0_o      (pend_dest),
    .pend1_o      (pend_src1),
    .pend2_o      (pend_src2),
    .busy_mask_o  (busy_mask)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    opcode_d    = opcode_q;
    dest_d      = dest_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    imm_d       = imm_q;
    wr_en_d     = wr_en_q;
    if (accept) begin
      out_valid_d = 1'b1;
      opcode_d    = in_opc;
      dest_d      = in_dest;
      src1_d      = in_src1;
      src2_d      = in_src2;
      imm_d       = in_imm;
      wr_en_d     = in_wr;
    end else if (flush || (out_valid_q && out_ready)) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      opcode_q    <= OP_NOP;
      dest_q      <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      imm_q       <= '0;
      wr_en_q     <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      opcode_q    <= opcode_d;
      dest_q      <= dest_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      imm_q       <= imm_d;
      wr_en_q     <= wr_en_d;
    end
  end

  assign out_valid = out_valid_q;
  assign opcode    = opcode_q;
  assign dest      = dest_q;
  assign srcadd1   = src1_q;
  assign srcadd2   = src2_q;
  assign imm       = imm_q;
  assign wr_en     = wr_en_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, wr_en;
  logic [31:0] in_instr;
  logic [3:0]  opcode, dest, srcadd1, srcadd2, wb_dest;
  logic [15:0] imm, busy_mask;
  logic        wb_valid, flush;

  logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_wr_en;
  logic [31:0] n_in_instr;
  logic [3:0]  n_opcode, n_dest, n_srcadd1, n_srcadd2, n_wb_dest;
  logic [15:0] n_imm, n_busy_mask;
  logic        n_wb_valid, n_flush;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  instr_decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode), .dest(dest),
    .srcadd1(srcadd1), .srcadd2(srcadd2), .imm(imm), .wr_en(wr_en),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .flush(flush), .busy_mask(busy_mask)
  );

  instr_decode_stage #(.SB_ENABLE(1'b0)) dut_nosb (
    .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready), .in_instr(n_in_instr),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .opcode(n_opcode), .dest(n_dest),
    .srcadd1(n_srcadd1), .srcadd2(n_srcadd2), .imm(n_imm), .wr_en(n_wr_en),
    .wb_valid(n_wb_valid), .wb_dest(n_wb_dest), .flush(n_flush), .busy_mask(n_busy_mask)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_instr = 32'h1321_00AB; out_ready = 1'b1;
    wb_valid = 1'b0; wb_dest = 4'h0; flush = 1'b0;
    n_in_valid = 1'b0; n_in_instr = 32'h0; n_out_ready = 1'b1;
    n_wb_valid = 1'b0; n_wb_dest = 4'h0; n_flush = 1'b0;

    // Reset
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_opcode", 32'(opcode), 32'hF);
    chk("rst_dest", 32'(dest), 32'h0);
    chk("rst_src", {srcadd1, srcadd2}, 32'h0);
    chk("rst_imm", 32'(imm), 32'h0);
    chk("rst_wr_en", 32'(wr_en), 32'h0);
    chk("rst_busy", 32'(busy_mask), 32'h0);

    // Pass-through
    rst = 1'b0;
    #1;
    chk("pt_in_ready", 32'(in_ready), 32'h1);
    tick();
    chk("pt_out_valid", 32'(out_valid), 32'h1);
    chk("pt_fields", {opcode, dest, srcadd1, srcadd2, imm}, 32'h1321_00AB);
    chk("pt_wr_en", 32'(wr_en), 32'h1);
    chk("pt_busy", 32'(busy_mask), 32'h0008);

    // RAW stall: reader of r3 (dest 5)
    in_instr = 32'h2530_0000;
    #1;
    chk("raw_stall0", 32'(in_ready), 32'h0);
    tick();
    chk("raw_retired", 32'(out_valid), 32'h0);
    chk("raw_busy_hold", 32'(busy_mask), 32'h0008);
    #1;
    chk("raw_stall1", 32'(in_ready), 32'h0);
    tick();
    wb_valid = 1'b1; wb_dest = 4'h3;
    #1;
    chk("raw_bypass_ready", 32'(in_ready), 32'h1);
    tick();
    wb_valid = 1'b0;
    chk("raw_accepted", {28'(out_valid), dest}, {28'h1, 4'h5});
    chk("raw_src1", 32'(srcadd1), 32'h3);
    chk("raw_busy", 32'(busy_mask), 32'h0020);

    // Non-writers
    in_instr = 32'h8700_0000;
    tick();
    chk("str_op_wr", {opcode, 27'h0, wr_en}, {4'h8, 27'h0, 1'b0});
    chk("str_busy", 32'(busy_mask), 32'h0020);
    in_instr = 32'hA700_0000;
    tick();
    chk("cmp_op_wr", {opcode, 27'h0, wr_en}, {4'hA, 27'h0, 1'b0});
    chk("cmp_busy", 32'(busy_mask), 32'h0020);

    // Fill the scoreboard (r5 is already pending)
    for (int n = 0; n < 16; n++) begin
      if (n != 5) begin
        in_instr = {4'h1, 4'(n), 4'(n), 4'(n), 16'h0};
        tick();
      end
    end
    chk("fill_busy", 32'(busy_mask), 32'hFFFF);
    in_instr = 32'h1000_0000;
    #1;
    chk("full_writer_stall", 32'(in_ready), 32'h0);
    in_instr = 32'hFFFF_FFFF;
    #1;
    chk("nop_ready_full", 32'(in_ready), 32'h1);
    tick();
    chk("nop_fields", {opcode, dest, srcadd1, srcadd2, imm}, 32'hFFFF_FFFF);
    chk("nop_wr_en", 32'(wr_en), 32'h0);
    chk("nop_busy", 32'(busy_mask), 32'hFFFF);

    // Drain via writebacks
    in_valid = 1'b0;
    for (int n = 0; n < 16; n++) begin
      wb_valid = 1'b1; wb_dest = 4'(n);
      tick();
    end
    wb_valid = 1'b0;
    chk("drain_busy", 32'(busy_mask), 32'h0);
    chk("drain_out_valid", 32'(out_valid), 32'h0);

    // Backpressure
    in_valid = 1'b1; in_instr = 32'h3412_1234;
    tick();
    out_ready = 1'b0; in_instr = 32'h4600_0000;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      tick();
      chk("bp_hold", {opcode, dest, srcadd1, srcadd2, imm}, 32'h3412_1234);
      chk("bp_valid", 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'h1);
    tick();
    chk("bp_next", {24'h0, opcode, dest}, 32'h46);
    chk("bp_busy", 32'(busy_mask), 32'h0050);

    // Flush a held writer to r9
    in_instr = 32'h5900_0000;
    tick();
    chk("fl_held", {27'h0, out_valid, dest}, {27'h0, 1'b1, 4'h9});
    chk("fl_busy_pre", 32'(busy_mask), 32'h0250);
    flush = 1'b1; in_instr = 32'h6A00_0000;
    #1;
    chk("fl_in_ready", 32'(in_ready), 32'h0);
    tick();
    flush = 1'b0;
    chk("fl_out_valid", 32'(out_valid), 32'h0);
    chk("fl_busy", 32'(busy_mask), 32'h0050);

    // Set/clear collision on r4
    in_instr = 32'h7400_0000; wb_valid = 1'b1; wb_dest = 4'h4;
    #1;
    chk("col_ready", 32'(in_ready), 32'h1);
    tick();
    wb_valid = 1'b0; in_valid = 1'b0;
    chk("col_busy", 32'(busy_mask), 32'h0050);
    chk("col_dest", 32'(dest), 32'h4);

    // SB_ENABLE = 0: dependent pair must not stall
    n_in_valid = 1'b1; n_in_instr = 32'h1300_0000;
    tick();
    n_in_instr = 32'h2530_0000;
    #1;
    chk("nosb_ready", 32'(n_in_ready), 32'h1);
    tick();
    n_in_valid = 1'b0;
    chk("nosb_dest", 32'(n_dest), 32'h5);
    chk("nosb_busy", 32'(n_busy_mask), 32'h0028);

    // Reset mid-operation
    rst = 1'b1;
    tick();
    chk("mrst_busy", 32'(busy_mask), 32'h0);
    chk("mrst_valid", 32'(out_valid), 32'h0);
    chk("mrst_opcode", 32'(opcode), 32'hF);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
